// File: rtl/vga_timing_xga.sv
// XGA (1024x768 @ 60 Hz) raster timing generator: registered pixel/line counters with zero-latency blank/sync flags.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit wrapping frame counter output frame_cnt_out.
module vga_timing_xga #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_start_out
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt_out
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLANK    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_BLANK    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Counters are 11/10 bits wide, so larger rasters cannot be represented.
  generate
    if (H_TOTAL > 2048 || V_TOTAL > 1024 || H_ACTIVE < 1 || V_ACTIVE < 1 ||
        H_SYNC < 1 || V_SYNC < 1) begin : g_bad_params
      $error("vga_timing_xga: illegal timing parameter set");
    end
  endgenerate

  logic [10:0] h_next;
  logic [9:0]  v_next;
  logic        h_wrap;
  logic        frame_wrap;

  always_comb begin
    h_wrap     = (hcount_out == H_LAST);
    h_next     = h_wrap ? 11'd0 : hcount_out + 11'd1;
    v_next     = vcount_out;
    frame_wrap = 1'b0;
    if (h_wrap) begin
      if (vcount_out == V_LAST) begin
        v_next     = 10'd0;
        frame_wrap = 1'b1;
      end else begin
        v_next = vcount_out + 10'd1;
      end
    end
  end

  // Flags are decoded from the next counts so they line up with the counts registered alongside them.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out      <= '0;
      vcount_out      <= '0;
      hblnk_out       <= 1'b0;
      vblnk_out       <= 1'b0;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      frame_start_out <= 1'b0;
    end else begin
      hcount_out      <= h_next;
      vcount_out      <= v_next;
      hblnk_out       <= (h_next >= H_BLANK);
      vblnk_out       <= (v_next >= V_BLANK);
      hsync_out       <= (h_next >= HS_FIRST) && (h_next <= HS_LAST);
      vsync_out       <= (v_next >= VS_FIRST) && (v_next <= VS_LAST);
      frame_start_out <= frame_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_out <= '0;
    end else if (frame_wrap) begin
      frame_cnt_out <= frame_cnt_out + 16'd1;
    end
  end
`endif

endmodule
